// File: rtl/grayscale_mode_ctrl.sv
// Frame-aligned controller for the grayscale converter enable: mode requests are
// applied only at a vblank rising edge, with a frame hold-off and a stalled-video timeout.
//   state | meaning
//   IDLE  | ready for a request
//   PEND  | request latched, waiting for vblank edge or timeout
//   APPLY | one cycle, gray_en takes the request
//   HOLD  | counting vblank edges before accepting again
module grayscale_mode_ctrl #(
  parameter int unsigned HOLD_FRAMES  = 2,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter bit          DEFAULT_GRAY = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic cfg_valid_i,
  input  logic cfg_gray_i,
  output logic cfg_ready_o,
  input  logic vb_in_i,
  output logic gray_en_o,
  output logic pending_o,
  output logic switch_pulse_o,
  output logic timeout_evt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned FW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;
  localparam logic [FW-1:0] FRM_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0] FRM_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          gray_q, gray_d;
  logic          req_q, req_d;
  logic          vb_d_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          apply_q;
  logic          switch_pulse_q;
  logic          vb_rise;
  logic          tmo_evt;

  assign vb_rise = vb_in_i & ~vb_d_q;

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    frm_d   = frm_q;
    tmo_evt = 1'b0;
    case (state_q)
      IDLE: begin
        // A vblank edge in the handshake cycle does not count toward PEND.
        if (cfg_valid_i) begin
          req_d = cfg_gray_i;
          if (cfg_gray_i != gray_q) begin
            state_d = PEND;
            tmo_d   = '0;
          end
        end
      end
      PEND: begin
        if (vb_rise) begin
          state_d = APPLY;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = APPLY;
          tmo_evt = 1'b1;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      APPLY: begin
        gray_d  = req_q;
        frm_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (vb_rise) begin
          if (frm_q != FRM_MAX) frm_d = frm_q + FW'(1);
          if (frm_q >= FRM_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      gray_q         <= DEFAULT_GRAY;
      req_q          <= DEFAULT_GRAY;
      vb_d_q         <= 1'b1;
      tmo_q          <= '0;
      frm_q          <= '0;
      apply_q        <= 1'b0;
      switch_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gray_q         <= gray_d;
      req_q          <= req_d;
      vb_d_q         <= vb_in_i;
      tmo_q          <= tmo_d;
      frm_q          <= frm_d;
      // Pulse lands in the cycle after gray_en has visibly changed.
      apply_q        <= (state_q == APPLY);
      switch_pulse_q <= apply_q;
    end
  end

  assign cfg_ready_o    = (state_q == IDLE);
  assign pending_o      = (state_q == PEND) || (state_q == APPLY);
  assign gray_en_o      = gray_q;
  assign switch_pulse_o = switch_pulse_q;
  assign timeout_evt_o  = tmo_evt;

endmodule

// File: tb/tb_grayscale_mode_ctrl.sv
// Scoreboard bench for grayscale_mode_ctrl: a timestamp-based reference model
// queues per-cycle expected outputs; a negedge monitor compares them.
module tb_grayscale_mode_ctrl;

  localparam int unsigned HOLD_FRAMES  = 2;
  localparam int unsigned TIMEOUT      = 1000;
  localparam bit          DEFAULT_GRAY = 1'b0;

  logic clk_i = 1'b0;
  logic reset_n_i, cfg_valid_i, cfg_gray_i, vb_in_i;
  logic cfg_ready_o, gray_en_o, pending_o, switch_pulse_o, timeout_evt_o;

  grayscale_mode_ctrl #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .TIMEOUT     (TIMEOUT),
    .DEFAULT_GRAY(DEFAULT_GRAY)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_gray_i    (cfg_gray_i),
    .cfg_ready_o   (cfg_ready_o),
    .vb_in_i       (vb_in_i),
    .gray_en_o     (gray_en_o),
    .pending_o     (pending_o),
    .switch_pulse_o(switch_pulse_o),
    .timeout_evt_o (timeout_evt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic gray;
    logic ready;
    logic pending;
    logic sw;
    logic tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tmo_seen = 0;

  // Reference model: the pending request, apply moment and hold-off are tracked
  // as cycle timestamps / remaining-frame counts; -1 means "not active".
  int m_cyc = 0;
  bit m_mode, m_req, m_prev_vb, m_accepted;
  int m_wait_start = -1;
  int m_apply_at   = -1;
  int m_rises_left = -1;
  int m_sw_at      = -1;

  task automatic model_step(input bit rn, input bit v, input bit g, input bit vb);
    exp_t e;
    bit   rise, idle;
    m_accepted = 1'b0;
    if (!rn) begin
      m_mode = DEFAULT_GRAY; m_wait_start = -1; m_apply_at = -1;
      m_rises_left = -1; m_sw_at = -1; m_prev_vb = 1'b1;
      e = '{gray: DEFAULT_GRAY, ready: 1'b1, pending: 1'b0, sw: 1'b0, tmo: 1'b0};
    end else begin
      rise = vb && !m_prev_vb;
      m_prev_vb = vb;
      idle = (m_wait_start < 0) && (m_apply_at < 0) && (m_rises_left < 0);
      e.gray    = m_mode;
      e.ready   = idle;
      e.pending = (m_wait_start >= 0) || (m_apply_at == m_cyc);
      e.sw      = (m_cyc == m_sw_at);
      e.tmo     = 1'b0;
      if (idle) begin
        if (v) begin
          m_accepted = 1'b1;
          if (g != m_mode) begin
            m_req = g;
            m_wait_start = m_cyc + 1;
          end
        end
      end else if (m_wait_start >= 0) begin
        if (rise || (m_cyc - m_wait_start == int'(TIMEOUT) - 1)) begin
          e.tmo = !rise;
          m_wait_start = -1;
          m_apply_at = m_cyc + 1;
        end
      end else if (m_apply_at == m_cyc) begin
        m_mode = m_req;
        m_sw_at = m_cyc + 2;
        m_apply_at = -1;
        m_rises_left = HOLD_FRAMES;
      end else if (rise) begin
        m_rises_left--;
        if (m_rises_left == 0) m_rises_left = -1;
      end
    end
    exp_q.push_back(e);
    m_cyc++;
  endtask

  task automatic cycle(input bit rn, input bit v, input bit g, input bit vb);
    @(posedge clk_i);
    #1;
    reset_n_i = rn; cfg_valid_i = v; cfg_gray_i = g; vb_in_i = vb;
    model_step(rn, v, g, vb);
  endtask

  task automatic run(input int n, input bit v, input bit g, input bit vb);
    for (int i = 0; i < n; i++) cycle(1'b1, v, g, vb);
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) begin
      run(30, 1'b0, 1'b0, 1'b0);
      run(10, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic check_reset_now(input string name);
    #1;
    n_checks++;
    if (gray_en_o !== DEFAULT_GRAY || cfg_ready_o !== 1'b1 || pending_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: gray_en=%b cfg_ready=%b pending=%b, required %b 1 0",
               name, gray_en_o, cfg_ready_o, pending_o, DEFAULT_GRAY);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{gray: gray_en_o, ready: cfg_ready_o, pending: pending_o,
            sw: switch_pulse_o, tmo: timeout_evt_o};
      if (timeout_evt_o === 1'b1) tmo_seen++;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t {gray,ready,pending,switch,timeout}: got %b required %b",
                 $time, a, e);
      end
    end
  end

  initial begin
    int tmo_before;
    bit done;
    int vb_left, rst_left;
    bit vb_lvl, req_on, req_g, rn;

    reset_n_i = 1'b0; cfg_valid_i = 1'b0; cfg_gray_i = 1'b0; vb_in_i = 1'b1;
    #2;
    check_reset_now("reset_initial");

    // 1: release with vblank high, then an idle vblank edge
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b1);

    // 4: request matching current mode is absorbed
    run(3, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0);

    // 2: request grayscale, vblank rises 490 cycles after the handshake
    run(1, 1'b1, 1'b1, 1'b0);
    run(489, 1'b0, 1'b0, 1'b0);
    run(20, 1'b0, 1'b0, 1'b1);
    frames(3);

    // 3: stalled video forces the switch by timeout
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    tmo_before = tmo_seen;
    run(1, 1'b1, 1'b1, 1'b0);
    run(TIMEOUT + 10, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (tmo_seen - tmo_before != 1) begin
      n_fail++;
      $display("FAIL timeout_evt_count: got %0d required 1", tmo_seen - tmo_before);
    end

    // 5: request held through HOLD until accepted, then applied on next edge
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cycle(1'b1, 1'b1, 1'b0, (i % 40) >= 30);
      done = m_accepted;
    end
    frames(4);

    // 6: reset asserted three cycles into PEND
    run(1, 1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_now("reset_mid_pend");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    frames(4);

    // Randomized traffic with occasional long vblank stalls and resets
    vb_left = 0; vb_lvl = 1'b0; req_on = 1'b0; req_g = 1'b0; rst_left = 0;
    for (int i = 0; i < 12000; i++) begin
      if (vb_left == 0) begin
        vb_lvl = !vb_lvl;
        if (vb_lvl) vb_left = $urandom_range(1, 12);
        else if ($urandom_range(0, 9) == 0) vb_left = $urandom_range(1000, 1300);
        else vb_left = $urandom_range(5, 60);
      end
      vb_left--;
      if (rst_left == 0 && $urandom_range(0, 2999) == 0) rst_left = $urandom_range(1, 3);
      rn = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      if (!req_on && $urandom_range(0, 7) == 0) begin
        req_on = 1'b1;
        req_g  = 1'($urandom_range(0, 1));
      end
      cycle(rn, req_on, req_g, vb_lvl);
      if (m_accepted) req_on = 1'b0;
    end
    run(2, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
